// File: rtl/ksa_shuffler_if.sv
// ksa_shuffler_if: bundles the start/finish control, the secret key and the
// single-port S-RAM bus of the RC4 key-scheduling stage.
// master = the shuffler (drives the RAM bus), slave = controller / S-RAM side.
interface ksa_shuffler_if #(
    parameter int RAM_WIDTH = 8,
    parameter int KEY_BYTES = 3
);
    logic                   start;
    logic [8*KEY_BYTES-1:0] secret_key;
    logic [RAM_WIDTH-1:0]   ram_q;
    logic [RAM_WIDTH-1:0]   address;
    logic [RAM_WIDTH-1:0]   ram_in;
    logic                   write_enable;
    logic                   busy;
    logic                   finished;

    modport master (
        input  start, secret_key, ram_q,
        output address, ram_in, write_enable, busy, finished
    );

    modport slave (
        output start, secret_key, ram_q,
        input  address, ram_in, write_enable, busy, finished
    );
endinterface

// File: rtl/ksa_shuffler.sv
// ksa_shuffler: RC4 key-scheduling stage. Assumes the S-RAM already holds
// S[i]=i; for i=0..255 computes j += S[i] + key[i mod KEY_BYTES] and swaps
// S[i]/S[j] through a single-port RAM with two-cycle read latency.
// Optional feature: define KSA_SAME_INDEX_SKIP_EN to skip the read/swap of
// S[j] whenever the new j equals i (4-cycle iteration instead of 9).
//
// Control handshake: a rising edge of start (start & ~start_d) is accepted
// only in IDLE; busy is high from the first READ_I through NEXT of the last
// index; finished pulses for exactly one cycle in DONE. There is no
// back-pressure: the RAM must accept one access per cycle.
module ksa_shuffler #(
    parameter int RAM_WIDTH = 8,
    parameter int KEY_BYTES = 3
) (
    input  logic              clk,
    input  logic              reset,
    ksa_shuffler_if.master    bus,
    output logic [3:0]        dbg_state
);

    localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        READ_I  = 4'd1,
        WAIT_I  = 4'd2,
        LATCH_I = 4'd3,
        READ_J  = 4'd4,
        WAIT_J  = 4'd5,
        LATCH_J = 4'd6,
        WRITE_I = 4'd7,
        WRITE_J = 4'd8,
        NEXT    = 4'd9,
        DONE    = 4'd10
    } state_t;

    state_t               state_q, state_d;
    logic [RAM_WIDTH-1:0] i_q, i_d;
    logic [RAM_WIDTH-1:0] j_q, j_d;
    logic [RAM_WIDTH-1:0] si_q, si_d;
    logic [RAM_WIDTH-1:0] sj_q, sj_d;
    logic [KW-1:0]        kidx_q, kidx_d;
    logic                 start_d;
    logic                 start_rise;
    logic [7:0]           key_byte;
    logic [RAM_WIDTH-1:0] j_sum;

    // Next values of the registered RAM-bus and status outputs.
    logic [RAM_WIDTH-1:0] addr_d;
    logic [RAM_WIDTH-1:0] din_d;
    logic                 we_d;
    logic                 busy_d;
    logic                 fin_d;

    assign start_rise = bus.start & ~start_d;
    assign dbg_state  = state_q;

    // Select the current key byte; byte 0 is the most significant byte.
    always_comb begin
        key_byte = 8'd0;
        for (int k = 0; k < KEY_BYTES; k++) begin
            if (kidx_q == KW'(k)) begin
                key_byte = bus.secret_key[8*(KEY_BYTES-1-k) +: 8];
            end
        end
    end

    // New j as it would be latched in LATCH_I (wraps mod 2^RAM_WIDTH).
    assign j_sum = j_q + bus.ram_q + RAM_WIDTH'(key_byte);

    // Next-state logic plus the outputs for the state being entered, so the
    // registered outputs line up with the state register.
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        si_d    = si_q;
        sj_d    = sj_q;
        kidx_d  = kidx_q;

        case (state_q)
            IDLE: begin
                if (start_rise) begin
                    state_d = READ_I;
                end
            end
            READ_I:  state_d = WAIT_I;
            WAIT_I:  state_d = LATCH_I;
            LATCH_I: begin
                si_d = bus.ram_q;
                j_d  = j_sum;
`ifdef KSA_SAME_INDEX_SKIP_EN
                // Swapping S[i] with itself is a no-op, so skip it entirely.
                state_d = (j_sum == i_q) ? NEXT : READ_J;
`else
                state_d = READ_J;
`endif
            end
            READ_J:  state_d = WAIT_J;
            WAIT_J:  state_d = LATCH_J;
            LATCH_J: begin
                sj_d    = bus.ram_q;
                state_d = WRITE_I;
            end
            WRITE_I: state_d = WRITE_J;
            WRITE_J: state_d = NEXT;
            NEXT: begin
                if (i_q == '1) begin
                    state_d = DONE;
                end else begin
                    i_d     = i_q + 1'b1;
                    kidx_d  = (kidx_q == KW'(KEY_BYTES-1)) ? '0 : kidx_q + 1'b1;
                    state_d = READ_I;
                end
            end
            DONE: begin
                i_d     = '0;
                j_d     = '0;
                kidx_d  = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        addr_d = '0;
        din_d  = '0;
        we_d   = 1'b0;
        busy_d = 1'b0;
        fin_d  = 1'b0;

        case (state_d)
            READ_I, WAIT_I, LATCH_I, NEXT: begin
                addr_d = i_d;
                busy_d = 1'b1;
            end
            READ_J, WAIT_J, LATCH_J: begin
                addr_d = j_d;
                busy_d = 1'b1;
            end
            WRITE_I: begin
                addr_d = i_d;
                din_d  = sj_d;
                we_d   = 1'b1;
                busy_d = 1'b1;
            end
            WRITE_J: begin
                addr_d = j_d;
                din_d  = si_d;
                we_d   = 1'b1;
                busy_d = 1'b1;
            end
            DONE: begin
                fin_d = 1'b1;
            end
            default: ;
        endcase
    end

    // State, datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= IDLE;
            i_q              <= '0;
            j_q              <= '0;
            si_q             <= '0;
            sj_q             <= '0;
            kidx_q           <= '0;
            start_d          <= 1'b0;
            bus.address      <= '0;
            bus.ram_in       <= '0;
            bus.write_enable <= 1'b0;
            bus.busy         <= 1'b0;
            bus.finished     <= 1'b0;
        end else begin
            state_q          <= state_d;
            i_q              <= i_d;
            j_q              <= j_d;
            si_q             <= si_d;
            sj_q             <= sj_d;
            kidx_q           <= kidx_d;
            start_d          <= bus.start;
            bus.address      <= addr_d;
            bus.ram_in       <= din_d;
            bus.write_enable <= we_d;
            bus.busy         <= busy_d;
            bus.finished     <= fin_d;
        end
    end

endmodule

// File: tb/tb_ksa_shuffler.sv
// tb_ksa_shuffler: drives ksa_shuffler against a behavioural S-RAM with
// two-cycle read latency and checks it against a software RC4 KSA model.
module tb_ksa_shuffler;

  localparam int W = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] dbg_state;

  ksa_shuffler_if #(.RAM_WIDTH(8), .KEY_BYTES(3)) bus();

  ksa_shuffler #(.RAM_WIDTH(8), .KEY_BYTES(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // behavioural S-RAM: address at cycle N -> ram_q valid at cycle N+2
  logic [7:0] mem [256];
  logic [7:0] rd1;
  logic       ram_init;

  always @(posedge clk) begin
    if (ram_init) begin
      for (int k = 0; k < 256; k++) mem[k] <= 8'(k);
    end else if (bus.write_enable) begin
      mem[bus.address] <= bus.ram_in;
    end
    rd1       <= mem[bus.address];
    bus.ram_q <= rd1;
  end

  // monitor: cycle count from first busy, write and finished counts
  int   cyc, we_cnt, fin_cnt, fin_cyc;
  bit   started;
  logic mon_clr;

  always @(negedge clk) begin
    if (mon_clr) begin
      cyc = -1; we_cnt = 0; fin_cnt = 0; fin_cyc = -1; started = 0;
    end else begin
      if (bus.busy && !started) begin
        started = 1; cyc = 0;
      end else if (started) begin
        cyc++;
      end
      if (bus.write_enable) we_cnt++;
      if (bus.finished) begin
        fin_cnt++;
        if (fin_cyc < 0) fin_cyc = cyc;
      end
    end
  end

  // scoreboard
  int tests = 0;
  int fails = 0;
  logic [W-1:0] exp_q[$];
  int exp_cycles, exp_writes;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // software RC4 KSA model; also predicts cycle and write counts
  task automatic build_model(input logic [23:0] key);
    logic [7:0] s [256];
    logic [7:0] j, t, kb;
    bit skip;
    exp_q.delete();
    exp_cycles = 0;
    exp_writes = 0;
    j = 8'd0;
    for (int k = 0; k < 256; k++) s[k] = 8'(k);
    for (int i = 0; i < 256; i++) begin
      kb = key[23-8*(i%3) -: 8];
      j = j + s[i] + kb;
      skip = 0;
`ifdef KSA_SAME_INDEX_SKIP_EN
      skip = (j == 8'(i));
`endif
      if (skip) exp_cycles += 4;
      else begin
        exp_cycles += 9;
        exp_writes += 2;
      end
      t = s[i]; s[i] = s[j]; s[j] = t;
    end
    for (int k = 0; k < 256; k++) exp_q.push_back(s[k]);
  endtask

  // directed vectors for key 24'h010203, first three iterations
  typedef struct {
    int         cyc;
    bit         chk_out;
    logic [7:0] addr;
    logic       we;
    logic [7:0] din;
    int         mem_idx;
    logic [7:0] mem_exp;
  } vec_t;
  vec_t tbl[$];

  // driver tasks
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int c);
    int g = 0;
    while (cyc < c && g < 5000) begin
      step();
      g++;
    end
    check($sformatf("reach_cycle_%0d", c), cyc, c);
  endtask

  task automatic kick(input logic [23:0] key);
    step();
    bus.start = 1'b0;
    bus.secret_key = key;
    ram_init = 1'b1;
    mon_clr = 1'b1;
    step();
    step();
    ram_init = 1'b0;
    mon_clr = 1'b0;
    bus.start = 1'b1;
  endtask

  // mode: 0 plain, 1 vector table, 2 start re-rise while busy, 3 iteration-1 timing
  task automatic run_full(input logic [23:0] key, input int mode);
    int g;
    int c1;
    build_model(key);
    kick(key);
    if (mode == 1) begin
      for (int v = 0; v < tbl.size(); v++) begin
        wait_cyc(tbl[v].cyc);
        if (tbl[v].chk_out) begin
          check($sformatf("vec%0d_addr", v), bus.address, tbl[v].addr);
          check($sformatf("vec%0d_we", v), bus.write_enable, tbl[v].we);
          check($sformatf("vec%0d_busy", v), bus.busy, 1);
          if (tbl[v].we) check($sformatf("vec%0d_din", v), bus.ram_in, tbl[v].din);
        end
        if (tbl[v].mem_idx >= 0)
          check($sformatf("vec%0d_mem%0d", v, tbl[v].mem_idx), mem[tbl[v].mem_idx], tbl[v].mem_exp);
      end
    end
    if (mode == 2) begin
      wait_cyc(100);
      bus.start = 1'b0;
      wait_cyc(110);
      bus.start = 1'b1;
    end
    if (mode == 3) begin
`ifdef KSA_SAME_INDEX_SKIP_EN
      c1 = 4;
`else
      c1 = 9;
`endif
      wait_cyc(c1);
      check("iter1_read_addr", bus.address, 1);
      check("iter1_read_state", dbg_state, 1);
      check("iter0_writes", we_cnt, (c1 == 4) ? 0 : 2);
    end
    g = 0;
    while (fin_cnt == 0 && g < 3000) begin
      step();
      g++;
    end
    check($sformatf("done_cycle_%06h", key), fin_cyc, exp_cycles);
    repeat (20) step();
    check($sformatf("finished_pulses_%06h", key), fin_cnt, 1);
    check($sformatf("write_cycles_%06h", key), we_cnt, exp_writes);
    check($sformatf("busy_after_%06h", key), bus.busy, 0);
    check($sformatf("idle_after_%06h", key), dbg_state, 0);
    for (int k = 0; k < 256; k++)
      check($sformatf("ram_%06h_%0d", key, k), mem[k], exp_q.pop_front());
    bus.start = 1'b0;
  endtask

  task automatic run_abort(input logic [23:0] key);
    int w;
    kick(key);
    wait_cyc(1000);
    reset = 1'b1;
    bus.start = 1'b0;
    step();
    check("abort_state", dbg_state, 0);
    check("abort_we", bus.write_enable, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_finished", bus.finished, 0);
    w = we_cnt;
    repeat (2) step();
    reset = 1'b0;
    repeat (10) step();
    check("abort_no_more_writes", we_cnt, w);
    check("abort_no_finish", fin_cnt, 0);
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0;
    bus.secret_key = 24'h0;
    ram_init = 1'b1;
    mon_clr = 1'b1;

    tbl.push_back('{0,  1, 8'd0, 1'b0, 8'd0, -1, 8'd0});
    tbl.push_back('{3,  1, 8'd1, 1'b0, 8'd0, -1, 8'd0});
    tbl.push_back('{6,  1, 8'd0, 1'b1, 8'd1, -1, 8'd0});
    tbl.push_back('{7,  1, 8'd1, 1'b1, 8'd0, -1, 8'd0});
    tbl.push_back('{8,  0, 8'd0, 1'b0, 8'd0,  0, 8'd1});
    tbl.push_back('{8,  0, 8'd0, 1'b0, 8'd0,  1, 8'd0});
    tbl.push_back('{9,  1, 8'd1, 1'b0, 8'd0, -1, 8'd0});
    tbl.push_back('{12, 1, 8'd3, 1'b0, 8'd0, -1, 8'd0});
    tbl.push_back('{15, 1, 8'd1, 1'b1, 8'd3, -1, 8'd0});
    tbl.push_back('{16, 1, 8'd3, 1'b1, 8'd0, -1, 8'd0});
    tbl.push_back('{17, 0, 8'd0, 1'b0, 8'd0,  1, 8'd3});
    tbl.push_back('{17, 0, 8'd0, 1'b0, 8'd0,  3, 8'd0});
    tbl.push_back('{18, 1, 8'd2, 1'b0, 8'd0, -1, 8'd0});
    tbl.push_back('{21, 1, 8'd8, 1'b0, 8'd0, -1, 8'd0});
    tbl.push_back('{24, 1, 8'd2, 1'b1, 8'd8, -1, 8'd0});
    tbl.push_back('{25, 1, 8'd8, 1'b1, 8'd2, -1, 8'd0});
    tbl.push_back('{26, 0, 8'd0, 1'b0, 8'd0,  2, 8'd8});
    tbl.push_back('{26, 0, 8'd0, 1'b0, 8'd0,  8, 8'd2});

    repeat (3) step();
    check("rst_address", bus.address, 0);
    check("rst_ram_in", bus.ram_in, 0);
    check("rst_we", bus.write_enable, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_finished", bus.finished, 0);
    check("rst_state", dbg_state, 0);
    reset = 1'b0;
    ram_init = 1'b0;
    mon_clr = 1'b0;
    repeat (2) step();

    run_full(24'h010203, 1);
    run_full(24'h000000, 3);
    run_full(24'hFFFFFF, 2);
    run_abort(24'h010203);
    run_full(24'h010203, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
